// File: rtl/lsu_mem_stage_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } lsu_state_t;

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [3:0] be;
        unique case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] d;
        unique case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-bus request/response bundle between the LSU and memory.
interface lsu_mem_stage_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/lsu_mem_stage_load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = offset[1] ? rdata[31:16] : rdata[15:0];
        unique case (funct3)
            F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{16{half_v[15]}}, half_v};
            F3_LBU:  data_o = {24'h0, byte_v};
            F3_LHU:  data_o = {16'h0, half_v};
            default: data_o = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store controller; LSU_MISALIGN_TRAP_EN enables the
// misaligned-access trap (otherwise low address bits are ignored).
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               flush,
    lsu_mem_stage_if.master    bus,
    output logic               valid,
    output logic [31:0]        load_data,
    output logic               bus_err,
    output logic               misalign
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [31:0]      ld_q, ld_d;
    logic             err_q, err_d;
    logic             mis_q, mis_d;

    logic             idle, access, trap, we_s;
    logic [2:0]       f3_s;
    logic [31:0]      addr_s, wdata_s, ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((funct3[1:0] == 2'b01) & addr[0])
                | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign idle   = (state_q == S_IDLE);
    assign access = (mem_read | mem_write) & ~flush;

    // The IDLE cycle already presents the request, so it uses live inputs.
    assign f3_s    = idle ? funct3    : f3_q;
    assign addr_s  = idle ? addr      : addr_q;
    assign wdata_s = idle ? wdata     : wdata_q;
    assign we_s    = idle ? mem_write : we_q;

    assign bus.bus_req   = (idle & access & ~trap) | (state_q == S_REQ);
    assign bus.bus_we    = bus.bus_req & we_s;
    assign bus.bus_addr  = {addr_s[31:2], 2'b00};
    assign bus.bus_be    = bus.bus_req ? store_be(f3_s, addr_s[1:0]) : 4'b0000;
    assign bus.bus_wdata = store_wdata(f3_s, wdata_s);

    lsu_load_extend u_ext (
        .rdata  (bus.bus_rdata),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data_o (ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        ld_d    = ld_q;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = mem_write;
                    cnt_d   = '0;
                    if (trap) begin
                        state_d = S_DONE;
                        mis_d   = 1'b1;
                    // A grant seen while requesting from IDLE must be honoured.
                    end else if (bus.bus_gnt) begin
                        state_d = mem_write ? S_DONE : S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.bus_gnt) begin
                    cnt_d = '0;
                    if (we_q) state_d = flush ? S_IDLE  : S_DONE;
                    else      state_d = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.bus_rvalid) begin
                    state_d = S_DONE;
                    ld_d    = ext;
                end else if (flush) begin
                    state_d = S_DRAIN;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    ld_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (bus.bus_rvalid || cnt_q >= TO_LAST) state_d = S_IDLE;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ld_q    <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign valid     = (state_q == S_DONE);
    assign load_data = ld_q;
    assign bus_err   = valid & err_q;
    assign misalign  = valid & mis_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: vector table plus scoreboard.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        valid, bus_err, misalign;
    logic [31:0] load_data;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .flush     (flush),
        .bus       (bus),
        .valid     (valid),
        .load_data (load_data),
        .bus_err   (bus_err),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gw;
        int          rw;
        int          fl;
        logic        tr;
        logic        ev;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] ld;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
        logic        err;
        logic        mis;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_ld = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(string nm, logic st, logic [2:0] f3,
                                logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, int gw, int rw, int fl,
                                logic tr, logic ev, logic [3:0] be,
                                logic [31:0] bwd, logic [31:0] ld,
                                logic err);
        vec_t v;
        v.nm = nm; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd;
        v.gw = gw; v.rw = rw; v.fl = fl; v.tr = tr; v.ev = ev;
        v.be = be; v.bwd = bwd; v.ld = ld; v.err = err;
        return v;
    endfunction

    function automatic int exp_lat(vec_t v);
        if (v.tr) return 1;
        if (v.st) return v.gw + 1;
        if (v.rw < 0) return v.gw + TO + 1;
        return v.gw + v.rw + 1;
    endfunction

    task automatic run_vec(input vec_t v);
        bit   granted = 0;
        bit   first = 1;
        bit   seen = 0;
        int   gcyc = -1;
        int   stall = 0;
        int   budget;
        exp_t e;
        budget = v.ev ? exp_lat(v) + 8 : 12;
        @(posedge clk); #1;
        mem_read  = !v.st;
        mem_write = v.st;
        funct3    = v.f3;
        addr      = v.a;
        wdata     = v.wd;
        if (v.ev) begin
            e.ld  = (v.st || v.tr) ? last_ld : v.ld;
            e.err = v.err;
            e.mis = v.tr;
            e.lat = exp_lat(v);
            sb.push_back(e);
            last_ld = e.ld;
        end
        for (int cyc = 0; cyc < budget; cyc++) begin
            bus.bus_gnt    = (cyc >= v.gw) && !granted;
            bus.bus_rvalid = !v.st && granted && v.rw >= 0
                             && cyc == gcyc + v.rw;
            bus.bus_rdata  = bus.bus_rvalid ? v.rd : 32'h5A5A_A5A5;
            flush          = (cyc == v.fl);
            @(negedge clk);
            if (v.tr && bus.bus_req) chk({v.nm, " trap_req"}, 1, 0);
            if (bus.bus_req && first) begin
                first = 0;
                chk({v.nm, " addr"}, bus.bus_addr, {v.a[31:2], 2'b00});
                chk({v.nm, " be"}, {28'h0, bus.bus_be}, {28'h0, v.be});
                chk({v.nm, " we"}, {31'h0, bus.bus_we}, {31'h0, v.st});
                if (v.st) chk({v.nm, " wdata"}, bus.bus_wdata, v.bwd);
            end
            if (bus.bus_req && !bus.bus_gnt) stall++;
            if (bus.bus_req && bus.bus_gnt && !granted) begin
                granted = 1;
                gcyc = cyc;
            end
            if (valid) begin
                seen = 1;
                if (sb.size() == 0) begin
                    chk({v.nm, " spurious_valid"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({v.nm, " load_data"}, load_data, e.ld);
                    chk({v.nm, " bus_err"}, {31'h0, bus_err}, {31'h0, e.err});
                    chk({v.nm, " misalign"}, {31'h0, misalign}, {31'h0, e.mis});
                    chk({v.nm, " latency"}, cyc, e.lat);
                end
                break;
            end
            @(posedge clk); #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            funct3    = 3'b010;
            addr      = 32'hFFFF_FFFF;
            wdata     = 32'h0;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
        bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
        @(negedge clk);
        chk({v.nm, " valid_after"}, {31'h0, valid}, 32'h0);
        chk({v.nm, " req_after"}, {31'h0, bus.bus_req}, 32'h0);
        if (granted && !v.tr) chk({v.nm, " stall"}, stall, v.gw);
        if (v.ev && !seen) chk({v.nm, " valid_timeout"}, 0, 1);
        if (!v.ev) chk({v.nm, " ld_kept"}, load_data, last_ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.bus_gnt = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata = '0;

        vt.push_back(mk("lb_neg", 0, F3_LB, 32'h103, 0, 32'h8000_0000,
                        0, 2, -1, 0, 1, 4'b1000, 0, 32'hFFFF_FF80, 0));
        vt.push_back(mk("sh_hi", 1, F3_LH, 32'h202, 32'h0000_BEEF, 0,
                        0, 0, -1, 0, 1, 4'b1100, 32'hBEEF_BEEF, 0, 0));
        vt.push_back(mk("lw_stall", 0, F3_LW, 32'h300, 0, 32'h1234_5678,
                        5, 1, -1, 0, 1, 4'b1111, 0, 32'h1234_5678, 0));
        vt.push_back(mk("lbu", 0, F3_LBU, 32'h101, 0, 32'h0000_A500,
                        0, 1, -1, 0, 1, 4'b0010, 0, 32'h0000_00A5, 0));
        vt.push_back(mk("lh_neg", 0, F3_LH, 32'h106, 0, 32'h8001_7FFF,
                        1, 3, -1, 0, 1, 4'b1100, 0, 32'hFFFF_8001, 0));
        vt.push_back(mk("lhu", 0, F3_LHU, 32'h104, 0, 32'h8001_F00D,
                        0, 1, -1, 0, 1, 4'b0011, 0, 32'h0000_F00D, 0));
        vt.push_back(mk("sb", 1, F3_LB, 32'h401, 32'h1234_56AB, 0,
                        0, 0, -1, 0, 1, 4'b0010, 32'hABAB_ABAB, 0, 0));
        vt.push_back(mk("sw_stall", 1, F3_LW, 32'h500, 32'hCAFE_F00D, 0,
                        2, 0, -1, 0, 1, 4'b1111, 32'hCAFE_F00D, 0, 0));
        vt.push_back(mk("lb_pos", 0, F3_LB, 32'h100, 0, 32'h0000_007F,
                        0, 1, -1, 0, 1, 4'b0001, 0, 32'h0000_007F, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vt.push_back(mk("lw_trap", 0, F3_LW, 32'h101, 0, 32'hA1B2_C3D4,
                        0, 1, -1, 1, 1, 4'b1111, 0, 0, 0));
        vt.push_back(mk("sh_trap", 1, F3_LH, 32'h203, 32'h1111, 0,
                        0, 0, -1, 1, 1, 4'b1100, 0, 0, 0));
`else
        vt.push_back(mk("lw_unal", 0, F3_LW, 32'h101, 0, 32'hA1B2_C3D4,
                        0, 1, -1, 0, 1, 4'b1111, 0, 32'hA1B2_C3D4, 0));
`endif
        vt.push_back(mk("flush_wait", 0, F3_LW, 32'h700, 0, 32'hDEAD_BEEF,
                        0, 3, 2, 0, 0, 4'b1111, 0, 0, 0));
        vt.push_back(mk("flush_req", 1, F3_LW, 32'h710, 32'h5555, 0,
                        10, 0, 2, 0, 0, 4'b1111, 32'h5555, 0, 0));
        vt.push_back(mk("flush_gnt_rd", 0, F3_LW, 32'h720, 0, 32'hDEAD_BEEF,
                        1, 2, 1, 0, 0, 4'b1111, 0, 0, 0));
        vt.push_back(mk("flush_gnt_wr", 1, F3_LB, 32'h733, 32'h77, 0,
                        1, 0, 1, 0, 0, 4'b1000, 32'h7777_7777, 0, 0));
        vt.push_back(mk("flush_done", 1, F3_LW, 32'h740, 32'h9, 0,
                        0, 0, 1, 0, 1, 4'b1111, 32'h9, 0, 0));
        vt.push_back(mk("timeout", 0, F3_LW, 32'h600, 0, 0,
                        0, -1, -1, 0, 1, 4'b1111, 0, 32'h0, 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst bus_req", {31'h0, bus.bus_req}, 0);
        chk("rst bus_be", {28'h0, bus.bus_be}, 0);
        chk("rst valid", {31'h0, valid}, 0);
        chk("rst err_mis", {30'h0, bus_err, misalign}, 0);
        chk("rst load_data", load_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i]);

        // Reset in WAIT, then a late response that must be ignored.
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = F3_LW; addr = 32'h800;
        bus.bus_gnt = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_read = 1'b0; bus.bus_gnt = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst valid", {31'h0, valid}, 0);
        chk("midrst load_data", load_data, 0);
        last_ld = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("midrst late_valid", {31'h0, valid}, 0);
        @(posedge clk); #1;
        bus.bus_rvalid = 1'b0;
        @(negedge clk);
        chk("midrst idle_valid", {31'h0, valid}, 0);
        chk("midrst idle_req", {31'h0, bus.bus_req}, 0);
        chk("midrst ld_kept", load_data, last_ld);
        chk("sb empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
